// File: rtl/norm_writer_if.sv
// Pixel stream in and frame-buffer write port out for the normalization writer.
// The master view is the environment: it sources pixels and sinks buffer writes.
interface norm_writer_if #(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int ADDR_WIDTH      = 12
);
  logic                       s_axis_tvalid;
  logic                       s_axis_tready;
  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata;
  logic                       s_axis_tlast;
  logic                       mem_wr_en;
  logic [ADDR_WIDTH-1:0]      mem_wr_addr;
  logic [PIXEL_BIT_WIDTH-1:0] mem_wr_data;

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast,
    input  s_axis_tready, mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast,
    output s_axis_tready, mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/norm_writer.sv
// Front half of normalization: streams one frame into the frame buffer while tracking
// its maximum, then publishes the clamped maximum as norm_denominator and pulses ap_done.
module norm_writer #(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int FRAME_PIXELS    = 4096,
  parameter int ADDR_WIDTH      = $clog2(FRAME_PIXELS)
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       ap_start,
  output logic                       ap_done,
  output logic                       ap_idle,
  norm_writer_if.slave               bus,
  output logic [PIXEL_BIT_WIDTH-1:0] norm_denominator,
  output logic [ADDR_WIDTH:0]        pixel_count,
  output logic                       frame_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_COMMIT,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0]        CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]        LAST_BEAT = (ADDR_WIDTH+1)'(FRAME_PIXELS - 1);
  localparam logic [PIXEL_BIT_WIDTH-1:0] DENOM_MIN = PIXEL_BIT_WIDTH'(1);

  state_t                       state_q;
  logic                         ap_done_q;
  logic                         mem_wr_en_q;
  logic [ADDR_WIDTH-1:0]        mem_wr_addr_q;
  logic [PIXEL_BIT_WIDTH-1:0]   mem_wr_data_q;
  logic [PIXEL_BIT_WIDTH-1:0]   denom_q;
  logic [ADDR_WIDTH:0]          count_q;
  logic                         err_q;
  logic [PIXEL_BIT_WIDTH-1:0]   max_q;

  logic                         handshake;
  logic                         is_last_beat;
  logic                         frame_end;
  logic [PIXEL_BIT_WIDTH-1:0]   max_d;

  // Ready depends only on state so upstream never sees a tvalid->tready loop.
  assign bus.s_axis_tready = (state_q == S_WRITE);
  assign handshake         = bus.s_axis_tvalid && bus.s_axis_tready;
  assign is_last_beat      = (count_q == LAST_BEAT);
  assign frame_end         = bus.s_axis_tlast || is_last_beat;
  assign max_d             = (bus.s_axis_tdata > max_q) ? bus.s_axis_tdata : max_q;

  // NOTE: state registers use non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q       <= S_IDLE;
      ap_done_q     <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
      denom_q       <= DENOM_MIN;
      count_q       <= '0;
      err_q         <= 1'b0;
      max_q         <= '0;
    end else begin
      // NOTE: strobes default low here so they pulse for exactly one cycle when set below.
      ap_done_q   <= 1'b0;
      mem_wr_en_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (ap_start) begin
            state_q <= S_WRITE;
            count_q <= '0;
            max_q   <= '0;
            err_q   <= 1'b0;
          end
        end
        S_WRITE: begin
          if (handshake) begin
            mem_wr_en_q   <= 1'b1;
            mem_wr_addr_q <= count_q[ADDR_WIDTH-1:0];
            mem_wr_data_q <= bus.s_axis_tdata;
            count_q       <= count_q + CNT_ONE;
            max_q         <= max_d;
            if (frame_end) begin
              state_q <= S_COMMIT;
              // A good frame has tlast exactly on the final beat; anything else is an error.
              err_q   <= (bus.s_axis_tlast != is_last_beat);
            end
          end
        end
        S_COMMIT: begin
          state_q   <= S_DONE;
          ap_done_q <= 1'b1;
          denom_q   <= (max_q == '0) ? DENOM_MIN : max_q;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ap_done          = ap_done_q;
  assign ap_idle          = (state_q == S_IDLE);
  assign bus.mem_wr_en    = mem_wr_en_q;
  assign bus.mem_wr_addr  = mem_wr_addr_q;
  assign bus.mem_wr_data  = mem_wr_data_q;
  assign norm_denominator = denom_q;
  assign pixel_count      = count_q;
  assign frame_err        = err_q;

endmodule

// File: tb/tb_norm_writer.sv
// Scoreboard bench for norm_writer with a 16-pixel frame: expected buffer writes are
// queued as beats are driven and popped when the write port strobes.
module tb_norm_writer;
  localparam int PW = 10;
  localparam int FP = 16;
  localparam int AW = $clog2(FP);

  typedef struct {
    logic [AW-1:0] addr;
    logic [PW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          srst;
  logic          ap_start;
  logic          ap_done;
  logic          ap_idle;
  logic [PW-1:0] norm_denominator;
  logic [AW:0]   pixel_count;
  logic          frame_err;

  int            n_assert = 0;
  int            n_fail   = 0;
  wr_t           exp_q[$];
  logic          exp_wr   = 1'b0;
  logic [PW-1:0] fdata [32];

  always #5 clk = ~clk;

  norm_writer_if #(.PIXEL_BIT_WIDTH(PW), .ADDR_WIDTH(AW)) bus ();

  norm_writer #(.PIXEL_BIT_WIDTH(PW), .FRAME_PIXELS(FP)) dut (
    .clk              (clk),
    .srst             (srst),
    .ap_start         (ap_start),
    .ap_done          (ap_done),
    .ap_idle          (ap_idle),
    .bus              (bus.slave),
    .norm_denominator (norm_denominator),
    .pixel_count      (pixel_count),
    .frame_err        (frame_err)
  );

  // Write-port monitor: a write must follow exactly the cycles in which a beat was accepted.
  always @(posedge clk) begin
    logic prev_wr;
    wr_t  e;
    prev_wr = exp_wr;
    #2;
    if (!srst) begin
      n_assert++;
      if (bus.mem_wr_en !== prev_wr) begin
        n_fail++;
        $display("FAIL mem_wr_en: got %0b expected %0b at %0t", bus.mem_wr_en, prev_wr, $time);
      end
      if (prev_wr && bus.mem_wr_en === 1'b1) begin
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL wr_unexpected: got addr %0d data %0d expected no write at %0t",
                   bus.mem_wr_addr, bus.mem_wr_data, $time);
        end else begin
          e = exp_q.pop_front();
          if (bus.mem_wr_addr !== e.addr || bus.mem_wr_data !== e.data) begin
            n_fail++;
            $display("FAIL wr_beat: got addr %0d data %0d expected addr %0d data %0d at %0t",
                     bus.mem_wr_addr, bus.mem_wr_data, e.addr, e.data, $time);
          end
        end
      end
    end
  end

  task automatic expect_reset_state(input string tag);
    n_assert++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0 || bus.s_axis_tready !== 1'b0 ||
        bus.mem_wr_en !== 1'b0 || bus.mem_wr_addr !== '0 || bus.mem_wr_data !== '0 ||
        norm_denominator !== PW'(1) || pixel_count !== '0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got idle=%0b done=%0b rdy=%0b wen=%0b addr=%0d wdata=%0d den=%0d cnt=%0d err=%0b expected 1 0 0 0 0 0 1 0 0",
               tag, ap_idle, ap_done, bus.s_axis_tready, bus.mem_wr_en, bus.mem_wr_addr,
               bus.mem_wr_data, norm_denominator, pixel_count, frame_err);
    end
  endtask

  // Pulses ap_start from IDLE; returns at the negedge where the DUT sits in WRITE.
  task automatic start_frame(input logic [PW-1:0] held_denom);
    @(negedge clk);
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    n_assert++;
    if (bus.s_axis_tready !== 1'b1 || ap_idle !== 1'b0 || pixel_count !== '0 ||
        frame_err !== 1'b0 || norm_denominator !== held_denom) begin
      n_fail++;
      $display("FAIL start: got rdy=%0b idle=%0b cnt=%0d err=%0b den=%0d expected 1 0 0 0 %0d",
               bus.s_axis_tready, ap_idle, pixel_count, frame_err, norm_denominator, held_denom);
    end
  endtask

  // Offers n beats; the model accepts up to tlast or the frame length, whichever is first.
  // Any beat past that point is left pending on the bus.
  task automatic drive_beats(input int n, input int tlast_at, input int drop_pct);
    int k;
    int gaps;
    k = FP;
    if (tlast_at >= 0 && tlast_at + 1 < k) k = tlast_at + 1;
    if (n < k) k = n;
    for (int i = 0; i < k; i++) begin
      gaps = 0;
      while (drop_pct > 0 && gaps < 4 && $urandom_range(99) < drop_pct) begin
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tlast  = 1'b0;
        exp_wr            = 1'b0;
        gaps++;
        @(negedge clk);
      end
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = fdata[i];
      bus.s_axis_tlast  = (i == tlast_at);
      exp_wr            = 1'b1;
      exp_q.push_back('{addr: AW'(i), data: fdata[i]});
      n_assert++;
      if (ap_done !== 1'b0) begin
        n_fail++;
        $display("FAIL done_in_write: got %0b expected 0 at beat %0d", ap_done, i);
      end
      @(negedge clk);
    end
    exp_wr           = 1'b0;
    bus.s_axis_tlast = 1'b0;
    if (n > k) begin
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = fdata[k];
    end else begin
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tdata  = '0;
    end
  endtask

  // Called at the negedge after the final handshake (COMMIT); checks done timing and results.
  task automatic finish_frame(input logic [PW-1:0] exp_den, input int exp_cnt,
                              input logic exp_err, input bit poke_start);
    n_assert++;
    if (bus.s_axis_tready !== 1'b0 || ap_done !== 1'b0) begin
      n_fail++;
      $display("FAIL commit: got rdy=%0b done=%0b expected 0 0", bus.s_axis_tready, ap_done);
    end
    @(negedge clk);
    n_assert++;
    if (ap_done !== 1'b1 || norm_denominator !== exp_den || ap_idle !== 1'b0 ||
        bus.s_axis_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL done: got done=%0b den=%0d idle=%0b rdy=%0b expected 1 %0d 0 0",
               ap_done, norm_denominator, ap_idle, bus.s_axis_tready, exp_den);
    end
    if (poke_start) ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    n_assert++;
    if (ap_done !== 1'b0 || ap_idle !== 1'b1 || pixel_count !== (AW+1)'(exp_cnt) ||
        frame_err !== exp_err || norm_denominator !== exp_den || bus.s_axis_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL result: got done=%0b idle=%0b cnt=%0d err=%0b den=%0d rdy=%0b expected 0 1 %0d %0b %0d 0",
               ap_done, ap_idle, pixel_count, frame_err, norm_denominator, bus.s_axis_tready,
               exp_cnt, exp_err, exp_den);
    end
    @(negedge clk);
    n_assert++;
    if (ap_idle !== 1'b1 || bus.s_axis_tready !== 1'b0 || ap_done !== 1'b0) begin
      n_fail++;
      $display("FAIL stay_idle: got idle=%0b rdy=%0b done=%0b expected 1 0 0",
               ap_idle, bus.s_axis_tready, ap_done);
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL writes_missing: got %0d outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic load_ramp_frame();
    for (int i = 0; i < 15; i++) fdata[i] = PW'(i);
    fdata[15] = 10'd1023;
  endtask

  task automatic test_reset();
    srst              = 1'b1;
    ap_start          = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = 1'b0;
    #23;
    expect_reset_state("reset");
    @(negedge clk);
    srst = 1'b0;
    @(negedge clk);
    expect_reset_state("after_release");
  endtask

  task automatic test_full_frame();
    load_ramp_frame();
    start_frame(PW'(1));
    drive_beats(16, 15, 0);
    finish_frame(10'd1023, 16, 1'b0, 1'b1);
  endtask

  task automatic test_random_gaps();
    load_ramp_frame();
    start_frame(10'd1023);
    drive_beats(16, 15, 50);
    finish_frame(10'd1023, 16, 1'b0, 1'b0);
  endtask

  task automatic test_all_zero();
    for (int i = 0; i < FP; i++) fdata[i] = '0;
    start_frame(10'd1023);
    drive_beats(16, 15, 0);
    finish_frame(PW'(1), 16, 1'b0, 1'b0);
  endtask

  task automatic test_early_tlast();
    fdata[0] = 10'd7; fdata[1] = 10'd3; fdata[2] = 10'd9; fdata[3] = 10'd2; fdata[4] = 10'd4;
    start_frame(PW'(1));
    drive_beats(5, 4, 0);
    finish_frame(10'd9, 5, 1'b1, 1'b0);
    load_ramp_frame();
    start_frame(10'd9);
    drive_beats(16, 15, 0);
    finish_frame(10'd1023, 16, 1'b0, 1'b0);
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 20; i++) fdata[i] = PW'(100 + i);
    start_frame(10'd1023);
    drive_beats(20, -1, 0);
    finish_frame(10'd115, 16, 1'b1, 1'b0);
  endtask

  task automatic test_srst_abort();
    for (int i = 0; i < FP; i++) fdata[i] = PW'(50 + i);
    start_frame(10'd115);
    drive_beats(8, -1, 0);
    #2;
    srst = 1'b1;
    #1;
    expect_reset_state("abort_async");
    @(negedge clk);
    expect_reset_state("abort_held");
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_writes: got %0d outstanding expected 0", exp_q.size());
    end
    srst = 1'b0;
    @(negedge clk);
    expect_reset_state("abort_released");
    load_ramp_frame();
    start_frame(PW'(1));
    drive_beats(16, 15, 0);
    finish_frame(10'd1023, 16, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_random_gaps();
    test_all_zero();
    test_early_tlast();
    test_overrun();
    test_srst_abort();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
